// File: rtl/rs_gf16_pkg.sv
// Shared GF(16) definitions for the RS(15,11) decoder: field constants,
// the multiplicative inverse table and the key-equation state encoding.
package rs_gf16_pkg;

  localparam int SYM_W   = 4;
  localparam int NSYN    = 4;
  localparam int T       = 2;
  localparam int LAM_DEG = 2 * T;
  localparam logic [4:0] PRIM_POLY = 5'b10011;

  typedef logic [SYM_W-1:0] gf_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISC = 2'd1,
    ST_UPD  = 2'd2,
    ST_DONE = 2'd3
  } bm_state_e;

  // Inverse of a^k is a^(15-k); entry 0 is unused since 0 has no inverse.
  function automatic gf_t gf_inv(input gf_t a);
    gf_t r;
    case (a)
      4'h1:    r = 4'h1;
      4'h2:    r = 4'h9;
      4'h3:    r = 4'hE;
      4'h4:    r = 4'hD;
      4'h5:    r = 4'hB;
      4'h6:    r = 4'h7;
      4'h7:    r = 4'h6;
      4'h8:    r = 4'hF;
      4'h9:    r = 4'h2;
      4'hA:    r = 4'hC;
      4'hB:    r = 4'h5;
      4'hC:    r = 4'hA;
      4'hD:    r = 4'h4;
      4'hE:    r = 4'h3;
      4'hF:    r = 4'h8;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bm_error_locator_if.sv
// Syndrome-in / locator-out handshake bundle between the syndrome stage,
// the Berlekamp-Massey block and the Chien/Forney stage.
interface bm_error_locator_if;
  import rs_gf16_pkg::*;

  logic       in_valid;
  logic       in_ready;
  gf_t        s_0;
  gf_t        s_1;
  gf_t        s_2;
  gf_t        s_3;
  logic       out_valid;
  logic       out_ready;
  gf_t        lambda_1;
  gf_t        lambda_2;
  logic [1:0] num_err;
  logic       fail;

  modport master (
    output in_valid, s_0, s_1, s_2, s_3, out_ready,
    input  in_ready, out_valid, lambda_1, lambda_2, num_err, fail
  );

  modport slave (
    input  in_valid, s_0, s_1, s_2, s_3, out_ready,
    output in_ready, out_valid, lambda_1, lambda_2, num_err, fail
  );

endinterface

// File: rtl/gf16_mul.sv
// Combinational GF(16) multiplier: carry-less product reduced by x^4+x+1.
module gf16_mul
  import rs_gf16_pkg::*;
(
  input  gf_t i_a,
  input  gf_t i_b,
  output gf_t o_p
);

  logic [2*SYM_W-2:0] w_prod;

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if (i_b[i]) w_prod = w_prod ^ ({3'b000, i_a} << i);
    end
    // Fold the high terms back down, top bit first.
    for (int k = 2*SYM_W-2; k >= SYM_W; k--) begin
      if (w_prod[k]) w_prod = w_prod ^ ({2'b00, PRIM_POLY} << (k - SYM_W));
    end
  end

  assign o_p = w_prod[SYM_W-1:0];

endmodule

// File: rtl/bm_error_locator.sv
// Iterative Berlekamp-Massey key-equation solver for RS(15,11), t=2:
// four syndromes in, Lambda(x)=1+L1*x+L2*x^2 plus error count out.
module bm_error_locator
  import rs_gf16_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  bm_error_locator_if.slave io_bus
);

  bm_state_e  r_state;
  bm_state_e  w_state_next;
  logic       w_in_ready;

  gf_t        r_syn   [NSYN];
  gf_t        r_lam   [1:LAM_DEG];
  gf_t        r_bpoly [0:LAM_DEG-1];
  gf_t        r_bval;
  gf_t        r_d;
  logic [2:0] r_len;
  logic [2:0] r_m;
  logic [2:0] r_r;

  logic       r_out_valid;
  gf_t        r_lambda_1;
  gf_t        r_lambda_2;
  logic [1:0] r_num_err;
  logic       r_fail;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid) w_state_next = ST_DISC;
      end
      ST_DISC: w_state_next = ST_UPD;
      ST_UPD:  w_state_next = (r_r == 3'(NSYN)) ? ST_DONE : ST_DISC;
      ST_DONE: if (r_out_valid && io_bus.out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Discrepancy d = S_{r-1} + sum_{i=1..L} Lambda_i * S_{r-1-i}
  gf_t        w_disc_syn  [1:NSYN-1];
  gf_t        w_disc_prod [1:NSYN-1];
  gf_t        w_disc;
  logic [1:0] w_r_idx;

  genvar gi;
  generate
    for (gi = 1; gi < NSYN; gi++) begin : g_disc
      logic       w_use;
      logic [1:0] w_idx;
      assign w_use = (r_r > 3'(gi)) && (r_len >= 3'(gi));
      assign w_idx = 2'(r_r - 3'(gi + 1));
      assign w_disc_syn[gi] = w_use ? r_syn[w_idx] : '0;
      gf16_mul u_mul (
        .i_a (r_lam[gi]),
        .i_b (w_disc_syn[gi]),
        .o_p (w_disc_prod[gi])
      );
    end
  endgenerate

  assign w_r_idx = 2'(r_r - 3'd1);

  always_comb begin
    w_disc = r_syn[w_r_idx];
    for (int i = 1; i < NSYN; i++) w_disc = w_disc ^ w_disc_prod[i];
  end

  // Correction term (d/b) * x^m * B(x). B's x^4 term is never kept:
  // m >= 1 would push it beyond the x^4 slot of Lambda.
  gf_t  w_binv;
  gf_t  w_coef;
  gf_t  w_upd_prod [0:LAM_DEG-1];
  gf_t  w_lam_upd  [1:LAM_DEG];
  logic w_swap;

  assign w_binv = gf_inv(r_bval);

  gf16_mul u_coef (
    .i_a (r_d),
    .i_b (w_binv),
    .o_p (w_coef)
  );

  generate
    for (gi = 0; gi < LAM_DEG; gi++) begin : g_upd
      gf16_mul u_mul (
        .i_a (w_coef),
        .i_b (r_bpoly[gi]),
        .o_p (w_upd_prod[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int j = 1; j <= LAM_DEG; j++) begin
      w_lam_upd[j] = r_lam[j];
      for (int i = 0; i < LAM_DEG; i++) begin
        if (({1'b0, r_m} + 4'(i)) == 4'(j)) w_lam_upd[j] = w_lam_upd[j] ^ w_upd_prod[i];
      end
    end
  end

  assign w_swap = ({r_len, 1'b0} <= ({1'b0, r_r} - 4'd1));

  logic w_fail;

  always_comb begin
    w_fail = (r_len > 3'(T));
    for (int i = T + 1; i <= LAM_DEG; i++) begin
      if (r_lam[i] != '0) w_fail = 1'b1;
    end
    if (r_len == 3'd1 && r_lam[1] == '0) w_fail = 1'b1;
    if (r_len == 3'd2 && r_lam[2] == '0) w_fail = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NSYN; i++)    r_syn[i]   <= '0;
      for (int j = 1; j <= LAM_DEG; j++) r_lam[j]   <= '0;
      for (int i = 0; i < LAM_DEG; i++) r_bpoly[i] <= '0;
      r_bval      <= '0;
      r_d         <= '0;
      r_len       <= '0;
      r_m         <= '0;
      r_r         <= '0;
      r_out_valid <= 1'b0;
      r_lambda_1  <= '0;
      r_lambda_2  <= '0;
      r_num_err   <= '0;
      r_fail      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.in_valid) begin
            r_syn[0] <= io_bus.s_0;
            r_syn[1] <= io_bus.s_1;
            r_syn[2] <= io_bus.s_2;
            r_syn[3] <= io_bus.s_3;
            for (int j = 1; j <= LAM_DEG; j++) r_lam[j] <= '0;
            r_bpoly[0] <= 4'h1;
            for (int i = 1; i < LAM_DEG; i++) r_bpoly[i] <= '0;
            r_len  <= 3'd0;
            r_m    <= 3'd1;
            r_bval <= 4'h1;
            r_r    <= 3'd1;
          end
        end
        ST_DISC: r_d <= w_disc;
        ST_UPD: begin
          r_r <= r_r + 3'd1;
          if (r_d == '0) begin
            r_m <= r_m + 3'd1;
          end else begin
            for (int j = 1; j <= LAM_DEG; j++) r_lam[j] <= w_lam_upd[j];
            if (w_swap) begin
              r_len      <= r_r - r_len;
              r_bpoly[0] <= 4'h1;
              for (int i = 1; i < LAM_DEG; i++) r_bpoly[i] <= r_lam[i];
              r_bval     <= r_d;
              r_m        <= 3'd1;
            end else begin
              r_m <= r_m + 3'd1;
            end
          end
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_fail      <= w_fail;
            r_lambda_1  <= w_fail ? '0 : r_lam[1];
            r_lambda_2  <= w_fail ? '0 : r_lam[2];
            r_num_err   <= w_fail ? 2'd0 : r_len[1:0];
          end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.lambda_1  = r_lambda_1;
  assign io_bus.lambda_2  = r_lambda_2;
  assign io_bus.num_err   = r_num_err;
  assign io_bus.fail      = r_fail;

endmodule

// File: tb/tb_bm_error_locator.sv
// Directed bench for bm_error_locator: hand-computed locator vectors,
// output back-pressure and a mid-decode reset.
module tb_bm_error_locator;
  import rs_gf16_pkg::*;

  typedef struct packed {
    logic [15:0] syn;
    logic [3:0]  l1;
    logic [3:0]  l2;
    logic [1:0]  ne;
    logic        fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bm_error_locator_if u_if ();

  bm_error_locator u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (u_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // {S_0,S_1,S_2,S_3}, LAMBDA_1, LAMBDA_2, NUM_ERR, FAIL
  vec_t vecs [6] = '{
    '{16'h0000, 4'h0, 4'h0, 2'd0, 1'b0},
    '{16'h1111, 4'h1, 4'h0, 2'd1, 1'b0},
    '{16'h8CAF, 4'h8, 4'h0, 2'd1, 1'b0},
    '{16'h4836, 4'h2, 4'h0, 2'd1, 1'b0},
    '{16'h0001, 4'h0, 4'h0, 2'd0, 1'b1},
    '{16'h3592, 4'h3, 4'h2, 2'd2, 1'b0}
  };

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble_syn();
    u_if.s_0 = 4'($urandom);
    u_if.s_1 = 4'($urandom);
    u_if.s_2 = 4'($urandom);
    u_if.s_3 = 4'($urandom);
  endtask

  task automatic send(input logic [15:0] syn);
    int waitc = 0;
    @(negedge clk);
    u_if.s_0 = syn[15:12];
    u_if.s_1 = syn[11:8];
    u_if.s_2 = syn[7:4];
    u_if.s_3 = syn[3:0];
    u_if.in_valid = 1'b1;
    while (!u_if.in_ready && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("in_ready_at_send", 32'(u_if.in_ready), 32'd1);
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    scramble_syn();
  endtask

  task automatic wait_result(input string tag, input vec_t exp);
    int cyc = 0;
    while (!u_if.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'd9);
    check_eq({tag, "_lambda_1"}, 32'(u_if.lambda_1), 32'(exp.l1));
    check_eq({tag, "_lambda_2"}, 32'(u_if.lambda_2), 32'(exp.l2));
    check_eq({tag, "_num_err"}, 32'(u_if.num_err), 32'(exp.ne));
    check_eq({tag, "_uncorrectable"}, 32'(u_if.fail), 32'(exp.fl));
    $display("%s S=%h -> L1=%h L2=%h n=%0d unc=%0d after %0d cycles",
             tag, exp.syn, u_if.lambda_1, u_if.lambda_2, u_if.num_err, u_if.fail, cyc);
  endtask

  task automatic release_out();
    @(negedge clk);
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("out_valid_drop", 32'(u_if.out_valid), 32'd0);
    check_eq("in_ready_back", 32'(u_if.in_ready), 32'd1);
    @(negedge clk);
    u_if.out_ready = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.s_0 = '0;
    u_if.s_1 = '0;
    u_if.s_2 = '0;
    u_if.s_3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("rst_lambda_1", 32'(u_if.lambda_1), 32'd0);
    check_eq("rst_lambda_2", 32'(u_if.lambda_2), 32'd0);
    check_eq("rst_num_err", 32'(u_if.num_err), 32'd0);
    check_eq("rst_uncorrectable", 32'(u_if.fail), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].syn);
      wait_result($sformatf("vec%0d", i), vecs[i]);
      release_out();
    end

    // Back-pressure: result held while a new set waits on IN_VALID.
    send(vecs[5].syn);
    wait_result("hold_a", vecs[5]);
    @(negedge clk);
    u_if.s_0 = 4'h1;
    u_if.s_1 = 4'h1;
    u_if.s_2 = 4'h1;
    u_if.s_3 = 4'h1;
    u_if.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_eq("hold_in_ready", 32'(u_if.in_ready), 32'd0);
      check_eq("hold_out_valid", 32'(u_if.out_valid), 32'd1);
      check_eq("hold_lambda_1", 32'(u_if.lambda_1), 32'h3);
      check_eq("hold_lambda_2", 32'(u_if.lambda_2), 32'h2);
      check_eq("hold_num_err", 32'(u_if.num_err), 32'd2);
    end
    release_out();
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    scramble_syn();
    wait_result("hold_b", vecs[1]);
    release_out();

    // Reset during the r=2 update, then a clean decode.
    send(vecs[1].syn);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(u_if.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(u_if.in_ready), 32'd1);
    check_eq("midrst_lambda_1", 32'(u_if.lambda_1), 32'd0);
    check_eq("midrst_num_err", 32'(u_if.num_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(vecs[3].syn);
    wait_result("post_rst", vecs[3]);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
